sum_accum: RTL

SUM_ACCUM -- requirements
Module: sum_accum

---
 rtl/sum_accum.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sum_accum.sv
// -----------------------------------------------------------------------------
// sum_accum
//   Accumulates NUM_SAMPLES unsigned 8-bit samples from the upstream adder
//   stage into one saturating ACC_W-bit result. The result is offered to the
//   consumer with a valid/ready handshake. No new frame starts until the
//   consumer takes the pending result.
//
// Parameters
//   NUM_SAMPLES  samples per result (1..255)
//   ACC_W        accumulator width (8..24)
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   sum_in       unsigned sample from upstream
//   in_valid     sum_in holds a sample
//   in_ready     block accepts a sample this cycle (registered)
//   clear        synchronous abort of the frame; wins over everything else
//   acc_out      accumulated result, 0 while out_valid=0
//   out_sat      result saturated at 2^ACC_W-1, 0 while out_valid=0
//   out_valid    acc_out/out_sat valid
//   out_ready    consumer takes the result
//   sample_cnt   samples accepted in the current frame
//
// FSM states
//   state | meaning
//   IDLE  | no frame in progress, next accept starts a new frame
//   ACCUM | frame in progress, sample_cnt < NUM_SAMPLES
//   DONE  | result held on acc_out until out_ready
// -----------------------------------------------------------------------------
module sum_accum #(
  parameter int NUM_SAMPLES = 8,
  parameter int ACC_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       sum_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       sample_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] NUM_SAMPLES_L = 8'(NUM_SAMPLES);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic             sat;
  logic             ready_q;
  logic             valid_q;
  logic [7:0]       cnt;

  logic             accept;
  logic [ACC_W:0]   sum_ext;
  logic [7:0]       cnt_inc;

  assign accept  = in_valid & ready_q;
  // one extra bit so the carry out signals saturation
  assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - 8){1'b0}}, sum_in};
  assign cnt_inc = cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      sat     <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      cnt     <= '0;
    end else if (clear) begin
      state   <= IDLE;
      acc     <= '0;
      sat     <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            acc <= {{(ACC_W - 8){1'b0}}, sum_in};
            sat <= 1'b0;
            cnt <= 8'd1;
            if (NUM_SAMPLES_L == 8'd1) begin
              state   <= DONE;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end

        ACCUM: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (sum_ext[ACC_W]) begin
              acc <= '1;
              sat <= 1'b1;
            end else begin
              acc <= sum_ext[ACC_W-1:0];
            end
            cnt <= cnt_inc;
            if (cnt_inc == NUM_SAMPLES_L) begin
              state   <= DONE;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state   <= IDLE;
            acc     <= '0;
            sat     <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            cnt     <= '0;
          end
        end

        default: begin
          state   <= IDLE;
          acc     <= '0;
          sat     <= 1'b0;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

  assign in_ready   = ready_q;
  assign out_valid  = valid_q;
  assign sample_cnt = cnt;
  // partial sums stay internal until the frame completes
  assign acc_out    = valid_q ? acc : '0;
  assign out_sat    = valid_q & sat;

endmodule
